// File: rtl/fp32_pkg.sv
// Shared binary32 constants, the unpacked-operand record and the operand unpacker
// used by the add/sub pipeline.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int LATENCY = 7;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  // Denormals collapse to a signed zero, so man carries the hidden bit whenever it is non-zero.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.is_zero = (x[30:23] == '0);
    u.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
    u.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
    u.man     = u.is_zero ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_add_sub_if.sv
// Operand/result bundle of the add/sub core; the wrapper drives the master side.
interface fp_add_sub_if;
  logic        clk_en;
  logic        add_sub;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  modport master (output clk_en, add_sub, dataa, datab, input result);
  modport slave  (input clk_en, add_sub, dataa, datab, output result);
endinterface

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter for the 27-bit pre-normalisation sum;
// an all-zero input reports 27.
module fp_lzc27 (
  input  logic [26:0] din,
  output logic [4:0]  count
);

  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (din[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// Seven-stage binary32 adder/subtractor; clk_en freezes every stage at once, so the
// latency is counted in enabled edges only.
module fp_add_sub
  import fp32_pkg::*;
(
  input  logic        clock,
  input  logic        aclr,
  fp_add_sub_if.slave bus
);

  localparam logic [9:0] EXP_OVF = 10'(2 * BIAS + 1);

  fp_unpacked_t ua, ub;
  logic        swap;
  logic        exc_flag_d;
  logic [31:0] exc_val_d;
  logic        exc_flag_q [1:LATENCY-1];
  logic [31:0] exc_val_q  [1:LATENCY-1];

  logic        s1_sign_d, s1_eff_sub_d, s1_sign_q, s1_eff_sub_q;
  logic [7:0]  s1_big_exp_d, s1_small_exp_d, s1_big_exp_q, s1_small_exp_q;
  logic [23:0] s1_big_man_d, s1_small_man_d, s1_big_man_q, s1_small_man_q;

  logic        s2_sign_q, s2_eff_sub_q;
  logic [7:0]  s2_exp_q;
  logic [26:0] s2_big_m_d, s2_small_m_d, s2_big_m_q, s2_small_m_q;
  logic [7:0]  diff;
  logic [26:0] small_ext, small_shift, lost_mask;

  logic        s3_sign_q;
  logic [7:0]  s3_exp_q;
  logic [27:0] s3_sum_d, s3_sum_q;

  logic        s4_sign_q;
  logic [7:0]  s4_exp_q;
  logic [27:0] s4_sum_q;
  logic [4:0]  s4_lzc_d, s4_lzc_q;

  logic        s5_sign_q, s5_zero_d, s5_zero_q;
  logic [9:0]  s5_exp_d, s5_exp_q, exp_ext;
  logic [26:0] s5_man_d, s5_man_q;

  logic        s6_sign_q, s6_zero_q, round_up;
  logic [9:0]  s6_exp_d, s6_exp_q;
  logic [22:0] s6_frac_d, s6_frac_q;
  logic [24:0] man25;

  logic [31:0] result_d, result_q;

  // s1: unpack, fold add_sub into B's sign, order so the big operand has |A| >= |B|.
  always_comb begin
    ua = fp_unpack(bus.dataa);
    ub = fp_unpack(bus.datab);
    ub.sign = ub.sign ^ ~bus.add_sub;
    swap = {ub.exp, ub.man} > {ua.exp, ua.man};
    s1_sign_d      = swap ? ub.sign : ua.sign;
    s1_eff_sub_d   = ua.sign ^ ub.sign;
    s1_big_exp_d   = swap ? ub.exp : ua.exp;
    s1_small_exp_d = swap ? ua.exp : ub.exp;
    s1_big_man_d   = swap ? ub.man : ua.man;
    s1_small_man_d = swap ? ua.man : ub.man;

    exc_flag_d = 1'b1;
    exc_val_d  = QNAN;
    if (ua.is_nan || ub.is_nan) begin
      exc_val_d = QNAN;
    end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
      exc_val_d = QNAN;
    end else if (ua.is_inf) begin
      exc_val_d = PINF | {ua.sign, 31'b0};
    end else if (ub.is_inf) begin
      exc_val_d = PINF | {ub.sign, 31'b0};
    end else if (ua.is_zero && ub.is_zero) begin
      // Only (-0) + (-0) keeps a negative sign.
      exc_val_d = {ua.sign & ub.sign, 31'b0};
    end else begin
      exc_flag_d = 1'b0;
    end
  end

  // s2: align with guard/round/sticky; bits shifted past the sticky position are ORed into it.
  always_comb begin
    diff        = s1_big_exp_q - s1_small_exp_q;
    small_ext   = {s1_small_man_q, 3'b000};
    small_shift = '0;
    lost_mask   = '0;
    s2_big_m_d  = {s1_big_man_q, 3'b000};
    if (diff > 8'd26) begin
      s2_small_m_d = {26'b0, |s1_small_man_q};
    end else begin
      small_shift  = small_ext >> diff;
      lost_mask    = (27'd1 << diff) - 27'd1;
      s2_small_m_d = {small_shift[26:1], small_shift[0] | (|(small_ext & lost_mask))};
    end
  end

  // s3: |big| >= |small| keeps the difference non-negative.
  always_comb begin
    s3_sum_d = s2_eff_sub_q ? ({1'b0, s2_big_m_q} - {1'b0, s2_small_m_q})
                            : ({1'b0, s2_big_m_q} + {1'b0, s2_small_m_q});
  end

  // s4
  fp_lzc27 u_lzc (
    .din   (s3_sum_q[26:0]),
    .count (s4_lzc_d)
  );

  // s5: normalise; an exponent that would reach zero or below flushes to +0.
  always_comb begin
    exp_ext = {2'b00, s4_exp_q};
    if (s4_sum_q[27]) begin
      s5_man_d  = {s4_sum_q[27:2], s4_sum_q[1] | s4_sum_q[0]};
      s5_exp_d  = exp_ext + 10'd1;
      s5_zero_d = 1'b0;
    end else begin
      s5_man_d  = s4_sum_q[26:0] << s4_lzc_q;
      s5_exp_d  = exp_ext - {5'b0, s4_lzc_q};
      s5_zero_d = (s4_sum_q == '0) || (exp_ext <= {5'b0, s4_lzc_q});
    end
  end

  // s6: round to nearest even; a mantissa carry leaves 1.0 and bumps the exponent.
  always_comb begin
    round_up = s5_man_q[2] & (s5_man_q[1] | s5_man_q[0] | s5_man_q[3]);
    man25    = {1'b0, s5_man_q[26:3]} + {24'b0, round_up};
    if (man25[24]) begin
      s6_frac_d = man25[23:1];
      s6_exp_d  = s5_exp_q + 10'd1;
    end else begin
      s6_frac_d = man25[22:0];
      s6_exp_d  = s5_exp_q;
    end
  end

  // s7
  always_comb begin
    if (exc_flag_q[LATENCY-1]) begin
      result_d = exc_val_q[LATENCY-1];
    end else if (s6_zero_q) begin
      result_d = '0;
    end else if (s6_exp_q >= EXP_OVF) begin
      result_d = PINF | {s6_sign_q, 31'b0};
    end else begin
      result_d = {s6_sign_q, s6_exp_q[7:0], s6_frac_q};
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 1; i < LATENCY; i++) begin
        exc_flag_q[i] <= 1'b0;
        exc_val_q[i]  <= '0;
      end
      s1_sign_q <= 1'b0;  s1_eff_sub_q <= 1'b0;
      s1_big_exp_q <= '0; s1_small_exp_q <= '0;
      s1_big_man_q <= '0; s1_small_man_q <= '0;
      s2_sign_q <= 1'b0;  s2_eff_sub_q <= 1'b0;  s2_exp_q <= '0;
      s2_big_m_q <= '0;   s2_small_m_q <= '0;
      s3_sign_q <= 1'b0;  s3_exp_q <= '0;  s3_sum_q <= '0;
      s4_sign_q <= 1'b0;  s4_exp_q <= '0;  s4_sum_q <= '0;  s4_lzc_q <= '0;
      s5_sign_q <= 1'b0;  s5_zero_q <= 1'b0;  s5_exp_q <= '0;  s5_man_q <= '0;
      s6_sign_q <= 1'b0;  s6_zero_q <= 1'b0;  s6_exp_q <= '0;  s6_frac_q <= '0;
      result_q <= '0;
    end else if (bus.clk_en) begin
      exc_flag_q[1] <= exc_flag_d;
      exc_val_q[1]  <= exc_val_d;
      for (int i = 2; i < LATENCY; i++) begin
        exc_flag_q[i] <= exc_flag_q[i-1];
        exc_val_q[i]  <= exc_val_q[i-1];
      end
      s1_sign_q <= s1_sign_d;  s1_eff_sub_q <= s1_eff_sub_d;
      s1_big_exp_q <= s1_big_exp_d;  s1_small_exp_q <= s1_small_exp_d;
      s1_big_man_q <= s1_big_man_d;  s1_small_man_q <= s1_small_man_d;
      s2_sign_q <= s1_sign_q;  s2_eff_sub_q <= s1_eff_sub_q;  s2_exp_q <= s1_big_exp_q;
      s2_big_m_q <= s2_big_m_d;  s2_small_m_q <= s2_small_m_d;
      s3_sign_q <= s2_sign_q;  s3_exp_q <= s2_exp_q;  s3_sum_q <= s3_sum_d;
      s4_sign_q <= s3_sign_q;  s4_exp_q <= s3_exp_q;  s4_sum_q <= s3_sum_q;  s4_lzc_q <= s4_lzc_d;
      s5_sign_q <= s4_sign_q;  s5_zero_q <= s5_zero_d;  s5_exp_q <= s5_exp_d;  s5_man_q <= s5_man_d;
      s6_sign_q <= s5_sign_q;  s6_zero_q <= s5_zero_q;  s6_exp_q <= s6_exp_d;  s6_frac_q <= s6_frac_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed bench for fp_add_sub: reset, arithmetic corners, back-to-back issue,
// clk_en stalls and a mid-pipeline aclr.
module tb_fp_add_sub;

  logic clock;
  logic aclr;
  int   checks   = 0;
  int   failures = 0;

  fp_add_sub_if bus ();

  fp_add_sub dut (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.dataa   = '0;
    bus.datab   = '0;
    bus.add_sub = 1'b1;
  endtask

  // Issue one operation and return what result shows after the 7th enabled edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] r);
    @(negedge clock);
    bus.dataa = a; bus.datab = b; bus.add_sub = op; bus.clk_en = 1'b1;
    @(posedge clock);
    #1;
    idle_inputs();
    repeat (6) @(posedge clock);
    #1;
    r = bus.result;
  endtask

  task automatic drain();
    @(negedge clock);
    idle_inputs();
    bus.clk_en = 1'b1;
    repeat (7) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    idle_inputs();
    bus.clk_en = 1'b0;
    #12;
    checks++;
    if (bus.result !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset: result=%h expected=%h", bus.result, 32'h0);
    end
    @(negedge clock);
    aclr = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] va [21];
    logic [31:0] vb [21];
    logic        vop [21];
    logic [31:0] vexp [21];
    logic [31:0] r;
    va   = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
             32'h40400000, 32'h7FC00001, 32'h7F800000, 32'hFF800000, 32'h80000000,
             32'h00000000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h00000001,
             32'h00800001, 32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7F800000,
             32'h3F800000};
    vb   = '{32'h40000000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h40000000,
             32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
             32'h00000000, 32'h33800000, 32'h33800000, 32'h73000000, 32'h3F800000,
             32'h00800000, 32'h30000000, 32'h00000000, 32'hFF800000, 32'hFF800000,
             32'h33C00000};
    vop  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vexp = '{32'h40400000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'hBF800000,
             32'hBF800000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000,
             32'h00000000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h3F800000,
             32'h00000000, 32'h3F800000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
             32'h3F800001};
    for (int i = 0; i < 21; i++) begin
      run_op(va[i], vb[i], vop[i], r);
      $display("txn %0d a=%h b=%h add_sub=%0d result=%h", i, va[i], vb[i], vop[i], r);
      checks++;
      if (r !== vexp[i]) begin
        failures++;
        $display("FAIL arith_%0d: result=%h expected=%h", i, r, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.dataa = 32'h3F800000; bus.datab = 32'h3F800000; bus.add_sub = 1'b1; bus.clk_en = 1'b1;
    @(negedge clock);
    bus.dataa = 32'h40400000; bus.datab = 32'h3F800000;
    @(negedge clock);
    idle_inputs();
    repeat (5) @(posedge clock);
    #1;
    $display("txn b2b_first result=%h", bus.result);
    checks++;
    if (bus.result !== 32'h40000000) begin
      failures++;
      $display("FAIL b2b_first: result=%h expected=%h", bus.result, 32'h40000000);
    end
    @(posedge clock);
    #1;
    $display("txn b2b_second result=%h", bus.result);
    checks++;
    if (bus.result !== 32'h40800000) begin
      failures++;
      $display("FAIL b2b_second: result=%h expected=%h", bus.result, 32'h40800000);
    end
  endtask

  task automatic test_stall();
    drain();
    @(negedge clock);
    bus.dataa = 32'h3FC00000; bus.datab = 32'h3FC00000; bus.add_sub = 1'b1; bus.clk_en = 1'b1;
    @(posedge clock);
    #1;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.result !== 32'h00000000) begin
        failures++;
        $display("FAIL stall_hold_%0d: result=%h expected=%h", i, bus.result, 32'h0);
      end
    end
    @(negedge clock);
    bus.clk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.result !== 32'h00000000) begin
      failures++;
      $display("FAIL stall_edge6: result=%h expected=%h", bus.result, 32'h0);
    end
    @(posedge clock);
    #1;
    $display("txn stall_1p5_plus_1p5 result=%h", bus.result);
    checks++;
    if (bus.result !== 32'h40400000) begin
      failures++;
      $display("FAIL stall_edge7: result=%h expected=%h", bus.result, 32'h40400000);
    end
  endtask

  task automatic test_aclr();
    @(negedge clock);
    bus.dataa = 32'h3F800000; bus.datab = 32'h40000000; bus.add_sub = 1'b1; bus.clk_en = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (bus.result !== 32'h40400000) begin
      failures++;
      $display("FAIL aclr_prefill: result=%h expected=%h", bus.result, 32'h40400000);
    end
    #2;
    idle_inputs();
    aclr = 1'b1;
    #1;
    $display("txn aclr_pulse result=%h", bus.result);
    checks++;
    if (bus.result !== 32'h00000000) begin
      failures++;
      $display("FAIL aclr_immediate: result=%h expected=%h", bus.result, 32'h0);
    end
    @(negedge clock);
    aclr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.result !== 32'h00000000) begin
        failures++;
        $display("FAIL aclr_no_stale_%0d: result=%h expected=%h", i, bus.result, 32'h0);
      end
    end
  endtask

  initial begin
    aclr = 1'b1;
    bus.clk_en = 1'b0;
    idle_inputs();
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_aclr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
